// File: rtl/memory_rtl_unit.sv
// Single-port synchronous memory with a valid/activate request port.
// Flags out-of-range and protocol violations with a one-cycle error pulse.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous active-low reset (clears every word)
//   addr      : word address of the request
//   data_in   : write data
//   valid     : request qualifier
//   activate  : block enable; a request is serviced only when high
//   wr_rd_enb : 1 = write, 0 = read
//   error     : registered pulse for an illegal request
//   data_out  : registered read data (updates one edge after a read)
module memory_rtl_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    input  logic                  activate,
    input  logic                  wr_rd_enb,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_error;

    logic             w_accept;
    logic             w_in_range;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;

    // Compare with one extra bit so DEPTH == 2**ADDR_WIDTH cannot wrap.
    assign w_in_range = ({1'b0, addr} < LP_DEPTH);
    assign w_idx      = addr[IDX_W-1:0];
    assign w_accept   = valid && activate;
    assign w_wr_ok    = w_accept && w_in_range && wr_rd_enb;
    assign w_rd_ok    = w_accept && w_in_range && !wr_rd_enb;

    // Either an out-of-range access or a request while the block is
    // disabled; both leave memory and data_out untouched.
    assign w_err = valid && (!activate || !w_in_range);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_data_out <= '0;
            r_error    <= 1'b0;
        end else begin
            r_error <= w_err;
            if (w_wr_ok) begin
                r_mem[w_idx] <= data_in;
            end
            if (w_rd_ok) begin
                r_data_out <= r_mem[w_idx];
            end
        end
    end

    assign data_out = r_data_out;
    assign error    = r_error;

endmodule

// File: tb/tb_memory_rtl_unit.sv
// Scoreboard bench for memory_rtl_unit: directed requests push the
// expected post-edge outputs; a monitor pops and compares every cycle.
module tb_memory_rtl_unit;

    logic       clk;
    logic       reset;
    logic [4:0] addr;
    logic [7:0] data_in;
    logic       valid;
    logic       activate;
    logic       wr_rd_enb;
    logic       error;
    logic [7:0] data_out;

    typedef struct {
        logic [7:0] d;
        logic       e;
        string      n;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    memory_rtl_unit #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(8),
        .DEPTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .data_in(data_in),
        .valid(valid),
        .activate(activate),
        .wr_rd_enb(wr_rd_enb),
        .error(error),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request per cycle; edo/eerr are the outputs expected just
    // after the edge that samples this request.
    task automatic drive(input logic rst, input logic act,
                         input logic vld, input logic wr,
                         input logic [4:0] a, input logic [7:0] d,
                         input logic [7:0] edo, input logic eerr,
                         input string nm);
        exp_t x;
        @(negedge clk);
        reset     = rst;
        activate  = act;
        valid     = vld;
        wr_rd_enb = wr;
        addr      = a;
        data_in   = d;
        x.d = edo;
        x.e = eerr;
        x.n = nm;
        q.push_back(x);
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (data_out !== x.d || error !== x.e) begin
                    failures++;
                    $display("FAIL %s: data_out=%h error=%b expected data_out=%h error=%b",
                             x.n, data_out, error, x.d, x.e);
                end
            end
        end
    end

    initial begin
        logic [7:0] cur;
        checks   = 0;
        failures = 0;
        reset     = 1'b0;
        activate  = 1'b0;
        valid     = 1'b0;
        wr_rd_enb = 1'b0;
        addr      = '0;
        data_in   = '0;

        drive(0, 0, 0, 0, 5'd0, 8'h00, 8'h00, 0, "reset_state");
        drive(0, 0, 0, 0, 5'd0, 8'h00, 8'h00, 0, "reset_state");

        // Bulk reset
        for (int a = 0; a < 16; a++)
            drive(1, 1, 1, 1, 5'(a), 8'hA5, 8'h00, 0, "bulk_fill");
        drive(0, 1, 0, 0, 5'd0, 8'h00, 8'h00, 0, "bulk_reset");
        drive(0, 1, 0, 0, 5'd0, 8'h00, 8'h00, 0, "bulk_reset");
        for (int a = 0; a < 16; a++)
            drive(1, 1, 1, 0, 5'(a), 8'h00, 8'h00, 0, "read_after_reset");

        // Bulk write then bulk read
        for (int a = 0; a < 16; a++)
            drive(1, 1, 1, 1, 5'(a), 8'(a * 3 + 1), 8'h00, 0, "bulk_write");
        for (int a = 0; a < 16; a++)
            drive(1, 1, 1, 0, 5'(a), 8'h00, 8'(a * 3 + 1), 0, "bulk_read");

        // Interleaved write/read; the write cycle holds the previous data
        cur = 8'h2E;
        for (int a = 0; a < 16; a++) begin
            drive(1, 1, 1, 1, 5'(a), 8'(~a), cur, 0, "ilv_write_hold");
            drive(1, 1, 1, 0, 5'(a), 8'h00, 8'(~a), 0, "ilv_read");
            cur = 8'(~a);
        end

        // Out-of-range writes leave memory intact
        for (int a = 16; a < 32; a++)
            drive(1, 1, 1, 1, 5'(a), 8'h77, 8'hF0, 1, "oor_write");
        for (int a = 0; a < 16; a++)
            drive(1, 1, 1, 0, 5'(a), 8'h00, 8'(~a), 0, "post_oor_read");

        // Out-of-range reads hold data_out
        drive(1, 1, 1, 1, 5'd7, 8'h42, 8'hF0, 0, "set42_write");
        drive(1, 1, 1, 0, 5'd7, 8'h00, 8'h42, 0, "set42_read");
        for (int a = 16; a < 32; a++)
            drive(1, 1, 1, 0, 5'(a), 8'h00, 8'h42, 1, "oor_read");

        // Protocol error, then idle, then confirm addr 3 untouched
        drive(1, 0, 1, 1, 5'd3, 8'h99, 8'h42, 1, "proto_write");
        drive(1, 0, 1, 0, 5'd4, 8'h00, 8'h42, 1, "proto_read");
        drive(1, 1, 0, 1, 5'd3, 8'h55, 8'h42, 0, "idle_write");
        drive(1, 1, 0, 0, 5'd3, 8'h00, 8'h42, 0, "idle_read");
        drive(1, 1, 1, 0, 5'd3, 8'h00, 8'hFC, 0, "addr3_unchanged");

        // Mid-stream reset drops a concurrent write and clears memory
        drive(0, 1, 1, 1, 5'd0, 8'h11, 8'h00, 0, "reset_with_req");
        drive(1, 1, 1, 0, 5'd0, 8'h00, 8'h00, 0, "read0_after_reset");
        drive(1, 1, 1, 0, 5'd15, 8'h00, 8'h00, 0, "read15_after_reset");
        drive(1, 1, 1, 0, 5'd16, 8'h00, 8'h00, 1, "oor_after_reset");
        drive(1, 1, 0, 0, 5'd0, 8'h00, 8'h00, 0, "error_clears");

        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 20 && q.size() > 0; k++)
            @(posedge clk);
        #2;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected pending=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_rtl_unit.md
Name: memory_rtl_unit

Overview:
Single-port synchronous read/write memory block with a simple valid/activate request interface and an error flag for illegal accesses. It connects to the memory_interface signal bundle. Writes and reads share the address and control lines, and direction is selected by wr_rd_enb. It is the storage endpoint exercised by bulk, sequential and out-of-range access tests.

Parameters:
ADDR_WIDTH, 5, width of addr; addressable range 0..2^ADDR_WIDTH-1.
DATA_WIDTH, 8, width of data_in / data_out and of each memory word.
DEPTH, 16, number of implemented words; legal addresses are 0..DEPTH-1. DEPTH must be <= 2^ADDR_WIDTH.

Ports:
clk  input  1  single clock; all state changes on rising edge.
reset  input  1  synchronous, active-low reset, sampled on rising clk.
addr  input  ADDR_WIDTH  word address of the request.
data_in  input  DATA_WIDTH  write data.
valid  input  1  request qualifier; a request exists only when high.
activate  input  1  block enable; requests are serviced only when high.
wr_rd_enb  input  1  1 = write, 0 = read.
error  output  1  registered error pulse for an illegal request.
data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (reset==0 at posedge): all DEPTH words cleared to 0; data_out=0; error=0. Reset has priority over any concurrent request. A request in the same cycle is dropped and has no effect.
- Accepted request: reset==1, activate==1, valid==1 at posedge.
- Legal write (accepted, wr_rd_enb=1, addr<DEPTH): mem[addr]<=data_in at that edge. data_out holds its previous value. error<=0.
- Legal read (accepted, wr_rd_enb=0, addr<DEPTH): data_out<=mem[addr] at that edge, so data is visible 1 cycle after the request edge. error<=0.
- Read-after-write to the same address on consecutive cycles returns the newly written data; there is no bypass requirement within the same edge.
- Out-of-range request (accepted, addr>=DEPTH): memory is unchanged; data_out holds its value; error<=1 for exactly that cycle. This applies to both reads and writes.
- Protocol error: valid==1 while activate==0. No access is performed; error<=1 for that cycle; data_out holds.
- Idle (valid==0): no access; error<=0; data_out holds.
- error is a per-request pulse, not sticky. Back-to-back illegal requests keep it high continuously.
- Back-to-back accepted requests are allowed every cycle with no wait states and no backpressure.
- Contents persist indefinitely between resets. A mid-stream reset clears all words; reads afterwards return 0.
- No X propagation: data_out and error are always driven from flops.

Test Plan:
- Bulk reset: write 0xA5 to addresses 0..15, assert reset=0 for 2 cycles, then read 0..15 -> every data_out = 0x00, error = 0 throughout.
- Bulk write then bulk read: write data = addr*3+1 to addresses 0..15 back-to-back, then read 0..15 back-to-back -> data_out one cycle after each read = addr*3+1 (e.g. addr 5 -> 0x10), error stays 0.
- Interleaved write/read: for each addr 0..15, write ~addr then read the same addr in the next cycle -> data_out = ~addr (addr 2 -> 0xFD).
- Unbounded write: write 0x77 to addresses 16..31 -> error = 1 in each following cycle; a subsequent read of 0..15 shows prior contents unchanged.
- Unbounded read: read addresses 16..31 after data_out = 0x42 -> error = 1 each cycle, data_out stays 0x42.
- Protocol and idle: valid=1 with activate=0 on a write of 0x99 to addr 3 -> error = 1, later read of addr 3 returns the old value. valid=0 with activate=1 -> error = 0 and no change.
